// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and an internal oversample tick.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit.
module uart_rx_os16 #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int OS_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      os_cnt, os_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shift, shift_n, data_n;
  logic            done_n, ferr_n;
  logic            data_bit, stop_bit;

`ifdef UART_RX_MAJORITY_EN
  // START begins at os_cnt=2 so that validation at 9 and the stop decision
  // at 9 fall on the same ticks as the single-sample build.
  localparam logic [3:0] START_OS = 4'd2;
  localparam logic [3:0] STOP_AT  = 4'd9;
  logic [1:0] samp, samp_n;
  logic       bit_v, bit_v_n, maj;
  assign maj      = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign data_bit = bit_v;
  assign stop_bit = maj;
`else
  localparam logic [3:0] START_OS = 4'd0;
  localparam logic [3:0] STOP_AT  = 4'd15;
  assign data_bit = rx_s;
  assign stop_bit = rx_s;
`endif

  assign tick    = (tick_cnt == TW'(OS_DIV - 1));
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      tick_cnt  <= '0;
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      samp      <= 2'b11;
      bit_v     <= 1'b1;
`endif
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      state     <= state_n;
      os_cnt    <= os_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= ferr_n;
`ifdef UART_RX_MAJORITY_EN
      samp      <= samp_n;
      bit_v     <= bit_v_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = rx_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    samp_n  = samp;
    bit_v_n = bit_v;
    if (tick && state != IDLE) begin
      if (os_cnt == 4'd7) samp_n[0] = rx_s;
      if (os_cnt == 4'd8) samp_n[1] = rx_s;
      if (os_cnt == 4'd9) bit_v_n   = maj;
    end
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          os_n    = START_OS;
        end
      end
      START: begin
        if (tick) begin
          os_n = os_cnt + 4'd1;
`ifdef UART_RX_MAJORITY_EN
          if (os_cnt == 4'd9 && maj) begin
            state_n = IDLE;
          end else if (os_cnt == 4'd15) begin
            state_n = DATA;
            os_n    = '0;
            bit_n   = '0;
          end
`else
          if (os_cnt == 4'd7) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              os_n    = '0;
              bit_n   = '0;
            end
          end
`endif
        end
      end
      DATA: begin
        if (tick) begin
          os_n = os_cnt + 4'd1;
          if (os_cnt == 4'd15) begin
            shift_n = {data_bit, shift[7:1]};
            os_n    = '0;
            if (bit_cnt == 3'd7) state_n = STOP;
            else                 bit_n   = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_n = os_cnt + 4'd1;
          // Leaving mid stop bit lets a back-to-back start edge be caught.
          if (os_cnt == STOP_AT) begin
            if (stop_bit) begin
              data_n = shift;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
            state_n = IDLE;
            os_n    = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at 16 clk per bit (OS_DIV=1).
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;

  uart_rx_os16 #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
    .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   done_cnt = 0, ferr_cnt = 0, both_cnt = 0, busy_low = 0;
  logic watch = 1'b0;
  int         done_cyc_q[$];
  logic [7:0] done_dat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      done_dat_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt++;
    if (rx_done && frame_err) both_cnt++;
    if (watch && !rx_busy) busy_low++;
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bd, bf, qn, t0, lat;
    logic [7:0] d44;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h43, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h80, 1'b0, 0, 1, 8'hFF};
    vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[6] = '{8'hC3, 1'b1, 1, 0, 8'hC3};

    // Reset held with idle line
    rst = 1'b0; rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_done", rx_done, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_data", rx_data, 8'h00);
    check("idle_busy", rx_busy, 1'b0);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_ferr_cnt", ferr_cnt, 0);
    @(posedge clk); #1;

    // Single frame 'G' with latency and busy tracking
    bd = done_cnt; qn = done_cyc_q.size(); t0 = cyc;
    fork
      send_frame(8'h47, 1'b1);
      begin
        repeat (6) @(posedge clk);
        watch = 1'b1;
        repeat (145) @(posedge clk);
        watch = 1'b0;
      end
    join
    idle(20);
    check("g_done_cnt", done_cnt - bd, 1);
    check("g_data", rx_data, 8'h47);
    lat = (done_cyc_q.size() > qn) ? done_cyc_q[qn] - t0 : -1;
    check_rng("g_latency", lat, 152, 156);
    check("g_busy_drop", busy_low, 0);

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      bd = done_cnt; bf = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      idle(40);
      check($sformatf("vec%0d_done", i), done_cnt - bd, vecs[i].exp_done);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - bf, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
    end

    // Back-to-back frames, no idle gap
    bd = done_cnt; qn = done_cyc_q.size();
    send_frame(8'h1B, 1'b1);
    send_frame(8'h6D, 1'b1);
    idle(40);
    check("b2b_done_cnt", done_cnt - bd, 2);
    if (done_cyc_q.size() >= qn + 2) begin
      check("b2b_data0", done_dat_q[qn], 8'h1B);
      check("b2b_data1", done_dat_q[qn+1], 8'h6D);
      check_rng("b2b_gap", done_cyc_q[qn+1] - done_cyc_q[qn], 158, 162);
    end else begin
      check("b2b_pulses_seen", done_cyc_q.size() - qn, 2);
    end

    // Short low glitch is rejected at mid start bit
    bd = done_cnt; bf = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_hi", rx_busy, 1'b1);
    idle(30);
    @(negedge clk);
    check("glitch_busy_lo", rx_busy, 1'b0);
    check("glitch_done", done_cnt - bd, 0);
    check("glitch_ferr", ferr_cnt - bf, 0);
    @(posedge clk); #1;

    // Reset in the middle of data bit 4 of 8'h44
    bd = done_cnt; bf = ferr_cnt; d44 = 8'h44;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d44[i]);
    rx = d44[4];
    repeat (8) @(posedge clk); #1;
    rst = 1'b0; rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_busy", rx_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(30);
    check("midrst_done", done_cnt - bd, 0);
    check("midrst_ferr", ferr_cnt - bf, 0);
    check("midrst_busy_after", rx_busy, 1'b0);
    bd = done_cnt;
    send_frame(8'h31, 1'b1);
    idle(40);
    check("after_rst_done", done_cnt - bd, 1);
    check("after_rst_data", rx_data, 8'h31);

    // Break: 400 low cycles give two framing errors; the third frame
    // straddles the rising edge and frames as 8'hE0 with a good stop.
    bd = done_cnt; bf = ferr_cnt;
    rx = 1'b0;
    repeat (400) @(posedge clk); #1;
    idle(100);
    check("break_ferr", ferr_cnt - bf, 2);
    check("break_done", done_cnt - bd, 1);
    check("break_data", rx_data, 8'hE0);

    check("done_ferr_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
